// File: rtl/decode_pkg.sv
// Shared decode widths and the ROB entry payload; the RAT uses the same widths.
package decode_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_IDX_W  = 4;
  localparam int FID_W      = 8;
  localparam int ARCH_REG_W = 5;

  typedef struct packed {
    logic [ARCH_REG_W-1:0] dst;
    logic [FID_W-1:0]      fid;
  } rob_entry_t;

endpackage

// File: rtl/decode_rob_if.sv
// Decode <-> reorder-buffer port bundle: flush, allocate, writeback and commit channels.
interface decode_rob_if import decode_pkg::*; #(parameter int DEPTH = ROB_DEPTH) ();

  localparam int IDX_W = $clog2(DEPTH);

  logic                  snoop_hit;
  logic                  bco_valid;
  logic                  alloc_valid;
  logic                  alloc_ready;
  logic [ARCH_REG_W-1:0] alloc_dst;
  logic [FID_W-1:0]      alloc_fid;
  logic [IDX_W-1:0]      alloc_rob;
  logic                  wb_valid;
  logic [IDX_W-1:0]      wb_rob;
  logic                  commit_valid;
  logic                  commit_ready;
  logic [ARCH_REG_W-1:0] commit_dst;
  logic [FID_W-1:0]      commit_fid;
  logic [IDX_W-1:0]      commit_rob;
  logic [IDX_W:0]        count;
  logic                  empty;

  modport master (
    output snoop_hit, bco_valid, alloc_valid, alloc_dst, alloc_fid,
           wb_valid, wb_rob, commit_ready,
    input  alloc_ready, alloc_rob, commit_valid, commit_dst, commit_fid,
           commit_rob, count, empty
  );

  modport slave (
    input  snoop_hit, bco_valid, alloc_valid, alloc_dst, alloc_fid,
           wb_valid, wb_rob, commit_ready,
    output alloc_ready, alloc_rob, commit_valid, commit_dst, commit_fid,
           commit_rob, count, empty
  );

endinterface

// File: rtl/decode_rob_ptr.sv
// Head/tail pointer pair with an extra wrap bit so full and empty are distinguishable.
module decode_rob_ptr #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     inc_tail,
  input  logic                     inc_head,
  output logic [$clog2(DEPTH)-1:0] head_idx,
  output logic [$clog2(DEPTH)-1:0] tail_idx,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] PTR_ONE = {{IDX_W{1'b0}}, 1'b1};

  logic [IDX_W:0] head;
  logic [IDX_W:0] tail;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (inc_tail) tail <= tail + PTR_ONE;
      if (inc_head) head <= head + PTR_ONE;
    end
  end

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];
  assign empty    = (head == tail);
  assign full     = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
  assign count    = tail - head;

endmodule

// File: rtl/decode_rob.sv
// In-order reorder buffer feeding the RAT commit port; flushes on BCO or snoop hit.
// Optional DECODE_ROB_WB_BYPASS_EN lets a same-cycle writeback to the head retire immediately.
module decode_rob import decode_pkg::*; #(
  parameter int DEPTH = ROB_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  decode_rob_if.slave  rob
);

  localparam int IDX_W = $clog2(DEPTH);

  rob_entry_t       entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] done;

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic             full;
  logic             is_empty;
  logic [IDX_W:0]   occupancy;

  logic flush;
  logic alloc_fire;
  logic head_done;
  logic commit_valid;
  logic commit_fire;

  assign flush      = rob.snoop_hit | rob.bco_valid;
  assign alloc_fire = rob.alloc_valid & ~full;

`ifdef DECODE_ROB_WB_BYPASS_EN
  assign head_done = done[head] | (rob.wb_valid && (rob.wb_rob == head));
`else
  assign head_done = done[head];
`endif

  assign commit_valid = ~is_empty & head_done;
  assign commit_fire  = commit_valid & rob.commit_ready;

  decode_rob_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .inc_tail (alloc_fire),
    .inc_head (commit_fire),
    .head_idx (head),
    .tail_idx (tail),
    .full     (full),
    .empty    (is_empty),
    .count    (occupancy)
  );

  // NOTE: the payload array is reset too, because the commit outputs expose the head entry
  // unconditionally and must read as zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      done  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      valid <= '0;
      done  <= '0;
    end else begin
      if (alloc_fire) begin
        entries[tail] <= '{dst: rob.alloc_dst, fid: rob.alloc_fid};
        valid[tail]   <= 1'b1;
        done[tail]    <= 1'b0;
      end
      // A writeback only counts against a live entry; stale indices are dropped.
      if (rob.wb_valid && valid[rob.wb_rob]) done[rob.wb_rob] <= 1'b1;
      if (commit_fire) valid[head] <= 1'b0;
    end
  end

  assign rob.alloc_ready  = ~full;
  assign rob.alloc_rob    = tail;
  assign rob.commit_valid = commit_valid;
  assign rob.commit_dst   = entries[head].dst;
  assign rob.commit_fid   = entries[head].fid;
  assign rob.commit_rob   = head;
  assign rob.count        = occupancy;
  assign rob.empty        = is_empty;

endmodule

// File: tb/tb_decode_rob.sv
// Directed bench for decode_rob: allocations push expected commits into a scoreboard,
// a monitor pops and compares every retirement.
module tb_decode_rob;
  import decode_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  decode_rob_if rif ();

  decode_rob dut (
    .clk   (clk),
    .reset (reset),
    .rob   (rif)
  );

`ifdef DECODE_ROB_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] dst;
    logic [7:0] fid;
    logic [3:0] rob;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   exp_tail    = 0;
  int   commits     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Commit monitor: every retirement must match the oldest outstanding allocation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 && rif.commit_valid === 1'b1 && rif.commit_ready === 1'b1 &&
          !rif.bco_valid && !rif.snoop_hit) begin
        commits++;
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL commit_unexpected: got rob %0d, expected no commit", rif.commit_rob);
        end else begin
          e = sb.pop_front();
          check("commit_entry", {rif.commit_dst, rif.commit_fid, rif.commit_rob}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Sample point for one cycle; records allocations the bench issued.
  task automatic at_neg();
    @(negedge clk);
    if (rif.bco_valid || rif.snoop_hit) begin
      sb.delete();
      exp_tail = 0;
    end else if (rif.alloc_valid) begin
      check("alloc_ready", rif.alloc_ready, 1);
      check("alloc_rob", rif.alloc_rob, exp_tail);
      sb.push_back({rif.alloc_dst, rif.alloc_fid, 4'(exp_tail)});
      exp_tail = (exp_tail + 1) % 16;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    rif.alloc_valid = 1'b0;
    rif.wb_valid    = 1'b0;
    rif.bco_valid   = 1'b0;
    rif.snoop_hit   = 1'b0;
  endtask

  task automatic alloc(input int dst, input int fid);
    rif.alloc_valid = 1'b1;
    rif.alloc_dst   = 5'(dst);
    rif.alloc_fid   = 8'(fid);
  endtask

  task automatic wb(input int idx);
    rif.wb_valid = 1'b1;
    rif.wb_rob   = 4'(idx);
  endtask

  task automatic drain(input int budget);
    rif.commit_ready = 1'b1;
    for (int n = 0; n < budget; n++) begin
      at_neg();
      if (rif.empty === 1'b1) break;
      adv();
    end
    check("drain_empty", rif.empty, 1);
    adv();
  endtask

  int base;
  int prev_rob;
  int c0;

  initial begin
    reset            = 1'b1;
    rif.snoop_hit    = 1'b0;
    rif.bco_valid    = 1'b0;
    rif.alloc_valid  = 1'b0;
    rif.alloc_dst    = '0;
    rif.alloc_fid    = '0;
    rif.wb_valid     = 1'b0;
    rif.wb_rob       = '0;
    rif.commit_ready = 1'b0;

    #12;
    check("rst_alloc_ready", rif.alloc_ready, 1);
    check("rst_alloc_rob", rif.alloc_rob, 0);
    check("rst_commit_valid", rif.commit_valid, 0);
    check("rst_commit_dst", rif.commit_dst, 0);
    check("rst_commit_fid", rif.commit_fid, 0);
    check("rst_commit_rob", rif.commit_rob, 0);
    check("rst_count", rif.count, 0);
    check("rst_empty", rif.empty, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill all 16 entries with no writeback.
    for (int i = 0; i < 16; i++) begin
      alloc((i * 3) % 32, 8'h10 + i);
      at_neg();
      check("fill_count", rif.count, i);
      check("fill_commit_valid", rif.commit_valid, 0);
      adv();
    end
    at_neg();
    check("full_alloc_ready", rif.alloc_ready, 0);
    check("full_count", rif.count, 16);
    check("full_commit_valid", rif.commit_valid, 0);
    check("full_empty", rif.empty, 0);
    adv();

    // Out-of-order writebacks 3, 1, 0 from the full state.
    wb(3); at_neg(); adv();
    wb(1); at_neg(); adv();
    wb(0); at_neg();
    check("wb0_same_cycle_cv", rif.commit_valid, BYP);
    adv();
    rif.commit_ready = 1'b1;
    at_neg();
    check("head0_cv", rif.commit_valid, 1);
    check("head0_fid", rif.commit_fid, 8'h10);
    check("head0_rob", rif.commit_rob, 0);
    check("retire_full_alloc_ready", rif.alloc_ready, 0);
    check("retire_full_count", rif.count, 16);
    adv();
    at_neg();
    check("head1_cv", rif.commit_valid, 1);
    check("head1_rob", rif.commit_rob, 1);
    check("after_retire_alloc_ready", rif.alloc_ready, 1);
    check("after_retire_count", rif.count, 15);
    adv();
    at_neg();
    check("head2_wait_cv", rif.commit_valid, 0);
    check("head2_rob", rif.commit_rob, 2);
    check("head2_count", rif.count, 14);
    adv();
    at_neg();
    check("head2_still_wait_cv", rif.commit_valid, 0);
    adv();
    wb(2); at_neg(); adv();
    for (int k = 4; k < 16; k++) begin
      wb(k); at_neg(); adv();
    end
    drain(20);

    // Steady state: one alloc and one commit per cycle with four entries in flight.
    rif.commit_ready = 1'b0;
    base = exp_tail;
    for (int j = 0; j < 4; j++) begin
      alloc(j, 8'h40 + j); at_neg(); adv();
    end
    for (int j = 0; j < 4; j++) begin
      wb((base + j) % 16); at_neg(); adv();
    end
    rif.commit_ready = 1'b1;
    prev_rob = 0;
    for (int j = 0; j < 40; j++) begin
      alloc(4 + j, 8'h44 + j);
      if (j > 0) wb(prev_rob);
      prev_rob = exp_tail;
      at_neg();
      check("steady_count", rif.count, 4);
      check("steady_cv", rif.commit_valid, 1);
      adv();
    end
    wb(prev_rob); at_neg(); adv();
    drain(20);

    // Branch correction with 7 entries (4 done, head not done) and alloc/commit requested.
    rif.commit_ready = 1'b0;
    base = exp_tail;
    for (int j = 0; j < 7; j++) begin
      alloc(j + 1, 8'h80 + j); at_neg(); adv();
    end
    for (int j = 1; j <= 4; j++) begin
      wb((base + j) % 16); at_neg(); adv();
    end
    c0 = commits;
    rif.bco_valid    = 1'b1;
    rif.commit_ready = 1'b1;
    alloc(9, 8'hEE);
    wb(base);
    at_neg();
    check("pre_flush_count", rif.count, 7);
    adv();
    at_neg();
    check("bco_count", rif.count, 0);
    check("bco_empty", rif.empty, 1);
    check("bco_alloc_rob", rif.alloc_rob, 0);
    check("bco_cv", rif.commit_valid, 0);
    check("bco_no_commit", commits, c0);
    adv();

    // Snoop-hit flush.
    rif.commit_ready = 1'b0;
    alloc(1, 8'h90); at_neg(); adv();
    alloc(2, 8'h91); wb(0); at_neg(); adv();
    rif.snoop_hit = 1'b1; at_neg(); adv();
    at_neg();
    check("snoop_count", rif.count, 0);
    check("snoop_empty", rif.empty, 1);
    adv();

    // Writeback to free index 9 must not leave a stale done bit.
    wb(9); at_neg(); adv();
    at_neg();
    check("free_wb_count", rif.count, 0);
    check("free_wb_empty", rif.empty, 1);
    check("free_wb_cv", rif.commit_valid, 0);
    adv();
    for (int j = 0; j < 10; j++) begin
      alloc(j, 8'hA0 + j); at_neg(); adv();
    end
    rif.commit_ready = 1'b1;
    for (int j = 0; j < 9; j++) begin
      wb(j); at_neg(); adv();
    end
    for (int n = 0; n < 20; n++) begin
      at_neg();
      if (rif.count === 5'd1) break;
      adv();
    end
    check("head9_count", rif.count, 1);
    check("head9_rob", rif.commit_rob, 9);
    check("head9_cv", rif.commit_valid, 0);
    adv();
    at_neg();
    check("head9_cv_hold", rif.commit_valid, 0);
    adv();
    wb(9); at_neg(); adv();
    drain(10);

    // Writeback-to-commit latency on entry 0.
    rif.bco_valid = 1'b1; at_neg(); adv();
    rif.commit_ready = 1'b1;
    alloc(7, 8'hC5); at_neg(); adv();
    wb(0); at_neg();
    check("lat_same_cycle_cv", rif.commit_valid, BYP);
    adv();
    at_neg();
    check("lat_next_cycle_cv", rif.commit_valid, !BYP);
    adv();
    at_neg();
    check("lat_empty", rif.empty, 1);
    adv();

    // Asynchronous reset mid-operation.
    rif.commit_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      alloc(j + 20, 8'hD0 + j); at_neg(); adv();
    end
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_count", rif.count, 0);
    check("async_rst_empty", rif.empty, 1);
    check("async_rst_alloc_ready", rif.alloc_ready, 1);
    check("async_rst_cv", rif.commit_valid, 0);
    check("async_rst_fid", rif.commit_fid, 0);
    sb.delete();
    exp_tail = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    alloc(3, 8'hE0); at_neg(); adv();
    wb(0); at_neg(); adv();
    drain(10);

    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
